// File: rtl/cronometro_ctrl.sv
// Stopwatch run-control sequencer: buttons -> counter enable/clear, lap freeze.
// Optional LAP_TIMEOUT_EN: lap freeze auto-releases after LAP_HOLD_MS ticks.
module cronometro_ctrl #(
    parameter int LAP_HOLD_MS = 3000,
    parameter int HOLD_W      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic       tick_ms,
    input  logic       max_reached,
    output logic       count_en,
    output logic       count_clr,
    output logic       lap_freeze,
    output logic [3:0] lap_idx,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_LAP   = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic       ss_prev_q, lap_prev_q, clr_prev_q;
    logic       ss_edge, lap_edge, clr_edge;
    logic [3:0] idx_q, idx_d;
    logic       clr_d;
    logic       en_q, clr_q, frz_q;
    logic       timeout;

    assign ss_edge  = btn_start_stop & ~ss_prev_q;
    assign lap_edge = btn_lap & ~lap_prev_q;
    assign clr_edge = btn_clear & ~clr_prev_q;

`ifdef LAP_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_q, hold_d;

    assign timeout = tick_ms && (hold_q == HOLD_W'(LAP_HOLD_MS - 1));
    assign hold_d  = (state_q == S_LAP && state_d == S_LAP)
                   ? hold_q + {{(HOLD_W-1){1'b0}}, tick_ms}
                   : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hold_q <= '0;
        else      hold_q <= hold_d;
    end
`else
    logic [HOLD_W-1:0] unused_hold;

    assign timeout     = 1'b0;
    assign unused_hold = HOLD_W'(LAP_HOLD_MS) ^ {HOLD_W{tick_ms}};
`endif

    // Ignored events do not block lower-priority ones; acting events do.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (clr_edge) begin
                    clr_d = 1'b1;
                    idx_d = 4'd0;
                end else if (ss_edge) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (max_reached) begin
                    state_d = S_DONE;
                end else if (ss_edge) begin
                    state_d = S_PAUSE;
                end else if (lap_edge) begin
                    state_d = S_LAP;
                    idx_d   = (idx_q == 4'd9) ? 4'd0 : idx_q + 4'd1;
                end
            end
            S_LAP: begin
                if (max_reached)   state_d = S_DONE;
                else if (ss_edge)  state_d = S_PAUSE;
                else if (lap_edge) state_d = S_RUN;
                else if (timeout)  state_d = S_RUN;
            end
            S_PAUSE: begin
                if (clr_edge) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                    idx_d   = 4'd0;
                end else if (ss_edge) begin
                    state_d = max_reached ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                if (clr_edge) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                    idx_d   = 4'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Button history resets high so a held button gives no edge at release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ss_prev_q  <= 1'b1;
            lap_prev_q <= 1'b1;
            clr_prev_q <= 1'b1;
            idx_q      <= 4'd0;
            en_q       <= 1'b0;
            clr_q      <= 1'b0;
            frz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ss_prev_q  <= btn_start_stop;
            lap_prev_q <= btn_lap;
            clr_prev_q <= btn_clear;
            idx_q      <= idx_d;
            en_q       <= (state_d == S_RUN) || (state_d == S_LAP);
            clr_q      <= clr_d;
            frz_q      <= (state_d == S_LAP);
        end
    end

    assign count_en   = en_q;
    assign count_clr  = clr_q;
    assign lap_freeze = frz_q;
    assign lap_idx    = idx_q;
    assign state      = state_q;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Randomized and directed bench for cronometro_ctrl against a behavioural model.
// Follows LAP_TIMEOUT_EN in the same way as the design.
module tb_cronometro_ctrl;

    localparam int HOLD = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start_stop, btn_lap, btn_clear, tick_ms, max_reached;
    logic       count_en, count_clr, lap_freeze;
    logic [3:0] lap_idx;
    logic [2:0] state;

    int n_chk = 0;
    int n_err = 0;

    // model: state as a plain number, laps counted modulo 10
    int m_st, m_laps, m_ticks;
    bit m_clr, p_ss, p_lap, p_clr;

    cronometro_ctrl #(.LAP_HOLD_MS(HOLD), .HOLD_W(12)) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .tick_ms        (tick_ms),
        .max_reached    (max_reached),
        .count_en       (count_en),
        .count_clr      (count_clr),
        .lap_freeze     (lap_freeze),
        .lap_idx        (lap_idx),
        .state          (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_laps = 0; m_ticks = 0; m_clr = 0;
        p_ss = 1; p_lap = 1; p_clr = 1;
    endtask

    task automatic model(input bit ss, lp, cl, tk, mx);
        bit es, el, ec, tmo;
        int nxt;
        es = ss && !p_ss; el = lp && !p_lap; ec = cl && !p_clr;
        p_ss = ss; p_lap = lp; p_clr = cl;
`ifdef LAP_TIMEOUT_EN
        tmo = tk && (m_ticks == HOLD - 1);
`else
        tmo = 0;
`endif
        nxt = m_st;
        m_clr = 0;
        if (m_st == 0) begin
            if (ec) begin m_clr = 1; m_laps = 0; end
            else if (es) nxt = 1;
        end else if (m_st == 1) begin
            if (mx) nxt = 4;
            else if (es) nxt = 2;
            else if (el) begin nxt = 3; m_laps = (m_laps + 1) % 10; end
        end else if (m_st == 3) begin
            if (mx) nxt = 4;
            else if (es) nxt = 2;
            else if (el || tmo) nxt = 1;
        end else if (m_st == 2) begin
            if (ec) begin nxt = 0; m_clr = 1; m_laps = 0; end
            else if (es) nxt = mx ? 4 : 1;
        end else begin
            if (ec) begin nxt = 0; m_clr = 1; m_laps = 0; end
        end
        m_ticks = (m_st == 3 && nxt == 3) ? m_ticks + int'(tk) : 0;
        m_st = nxt;
    endtask

    task automatic step(input bit ss, lp, cl, tk, mx);
        @(negedge clk);
        btn_start_stop = ss; btn_lap = lp; btn_clear = cl;
        tick_ms = tk; max_reached = mx;
        model(ss, lp, cl, tk, mx);
        @(posedge clk);
        #1;
        check("state", int'(state), m_st);
        check("count_en", int'(count_en), int'(m_st == 1 || m_st == 3));
        check("lap_freeze", int'(lap_freeze), int'(m_st == 3));
        check("count_clr", int'(count_clr), int'(m_clr));
        check("lap_idx", int'(lap_idx), m_laps);
    endtask

    // press-and-release helpers: 0=start_stop 1=lap 2=clear
    task automatic press(input int b);
        step(b == 0, b == 1, b == 2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_en"}, int'(count_en), 0);
        check({tag, "_clr"}, int'(count_clr), 0);
        check({tag, "_frz"}, int'(lap_freeze), 0);
        check({tag, "_idx"}, int'(lap_idx), 0);
    endtask

    initial begin
        bit ss, lp, cl;
        rst = 1'b0;
        btn_start_stop = 1'b1; btn_lap = 1'b0; btn_clear = 1'b0;
        tick_ms = 1'b0; max_reached = 1'b0;
        model_reset();
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("held_ss_state", int'(state), 0);
        check("held_ss_en", int'(count_en), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("start_state", int'(state), 1);
        check("start_en", int'(count_en), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lap_state", int'(state), 3);
        check("lap_frz", int'(lap_freeze), 1);
        check("lap_en", int'(count_en), 1);
        check("lap_idx1", int'(lap_idx), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("unlap_state", int'(state), 1);
        check("unlap_frz", int'(lap_freeze), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        press(0);
        check("pause_state", int'(state), 2);
        check("pause_en", int'(count_en), 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("clear_pulse", int'(count_clr), 1);
        check("clear_state", int'(state), 0);
        check("clear_idx", int'(lap_idx), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("clear_pulse_end", int'(count_clr), 0);

        press(0);
        press(2);
        check("run_clear_ignored", int'(count_clr), 0);
        check("run_clear_state", int'(state), 1);

        for (int i = 0; i < 10; i++) begin
            press(1);
            press(1);
        end
        check("lap_wrap", int'(lap_idx), 0);

        press(1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("max_state", int'(state), 4);
        check("max_en", int'(count_en), 0);
        check("max_frz", int'(lap_freeze), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        press(0);
        press(1);
        check("done_stuck", int'(state), 4);
        press(2);
        check("done_clear", int'(state), 0);

        press(0);
        press(1);
        for (int i = 0; i < HOLD; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (i < HOLD - 1) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
`ifdef LAP_TIMEOUT_EN
        check("lap_timeout", int'(state), 1);
`else
        for (int i = 0; i < 5000 - HOLD; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("lap_no_timeout", int'(state), 3);
`endif

        if (state == 3'd3) press(0);
        if (state == 3'd2) press(0);
        check("pre_async_state", int'(state), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_zero("async");
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        ss = 0; lp = 0; cl = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) ss = !ss;
            if ($urandom_range(0, 4) == 0) lp = !lp;
            if ($urandom_range(0, 9) == 0) cl = !cl;
            step(ss, lp, cl, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 19) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
